// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and width definitions for the ALU execution unit.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SRL  = 4'd3,
    OP_SRA  = 4'd4,
    OP_XOR  = 4'd5,
    OP_OR   = 4'd6,
    OP_AND  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_st_e;

  function automatic logic is_shift_op(input logic [ALU_OP_W-1:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Shifter for the ALU: combinational barrel (SHIFT_ITER=0) or a 1-bit-per-cycle
// iterative engine with its own IDLE/SHIFT FSM and remaining-count register.
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_ITER = 0,
  localparam int SHW       = $clog2(XLEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [XLEN-1:0]     a,
  input  logic [SHW-1:0]      amt,
  output logic                done,
  output logic                busy,
  output logic [XLEN-1:0]     result
);

  localparam bit ITER = (SHIFT_ITER != 0);

  logic [XLEN-1:0]     barrel_res;
  logic [XLEN-1:0]     step_res;
  alu_st_e             state_reg;
  logic [SHW-1:0]      cnt_reg;
  logic [XLEN-1:0]     work_reg;
  logic [ALU_OP_W-1:0] op_reg;
  logic                start_eff;

  always_comb begin
    barrel_res = a;
    case (op)
      OP_SLL:  barrel_res = a << amt;
      OP_SRL:  barrel_res = a >> amt;
      OP_SRA:  barrel_res = $unsigned($signed(a) >>> amt);
      default: barrel_res = a;
    endcase
  end

  always_comb begin
    step_res = {1'b0, work_reg[XLEN-1:1]};
    case (op_reg)
      OP_SLL:  step_res = {work_reg[XLEN-2:0], 1'b0};
      OP_SRA:  step_res = {work_reg[XLEN-1], work_reg[XLEN-1:1]};
      default: step_res = {1'b0, work_reg[XLEN-1:1]};
    endcase
  end

  // The FSM can only leave IDLE in the iterative build.
  assign start_eff = start & ITER;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      work_reg  <= '0;
      op_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_eff) begin
            state_reg <= ST_SHIFT;
            work_reg  <= a;
            cnt_reg   <= amt;
            op_reg    <= op;
          end
        end
        ST_SHIFT: begin
          work_reg <= step_res;
          cnt_reg  <= cnt_reg - SHW'(1);
          if (cnt_reg == SHW'(1)) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // The final step is handed out combinationally so the output register captures
  // it on the same edge the count reaches zero.
  assign busy   = (state_reg == ST_SHIFT);
  assign done   = busy && (cnt_reg == SHW'(1));
  assign result = ITER ? (busy ? step_res : a) : barrel_res;

endmodule

// File: rtl/alu_exu.sv
// Registered ALU execution unit: valid/ready in and out, tag pass-through,
// add/sub/compare/logic datapath and a barrel or iterative shifter.
module alu_exu
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 4,
  parameter int SHIFT_ITER = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] in_op,
  input  logic [XLEN-1:0]     in_a,
  input  logic [XLEN-1:0]     in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_res,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_err,
  output logic                busy
);

  localparam int SHW  = $clog2(XLEN);
  localparam bit ITER = (SHIFT_ITER != 0);

  logic              in_fire;
  logic              out_fire;
  logic              shift_start;
  logic              shift_done;
  logic              shift_busy;
  logic [XLEN-1:0]   shift_res;
  logic              sub_mode;
  logic [XLEN-1:0]   b_eff;
  logic [XLEN:0]     sum_ext;
  logic              slt_bit;
  logic              sltu_bit;
  logic [XLEN-1:0]   xor_res;
  logic [XLEN-1:0]   or_res;
  logic [XLEN-1:0]   and_res;
  logic [XLEN-1:0]   res_next;
  logic              err_next;
  logic              out_valid_reg;
  logic [XLEN-1:0]   out_res_reg;
  logic [TAG_W-1:0]  out_tag_reg;
  logic              out_err_reg;
  logic [TAG_W-1:0]  tag_hold_reg;

  assign in_ready = !rst && !shift_busy && (!out_valid_reg || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_reg && out_ready;

  // Zero-amount shifts never enter the FSM; they complete through the 1-cycle path.
  assign shift_start = in_fire && is_shift_op(in_op) && (in_b[SHW-1:0] != '0) && ITER;

  alu_shift_unit #(
    .XLEN       (XLEN),
    .SHIFT_ITER (SHIFT_ITER)
  ) u_shift (
    .clk    (clk),
    .rst    (rst),
    .start  (shift_start),
    .op     (in_op),
    .a      (in_a),
    .amt    (in_b[SHW-1:0]),
    .done   (shift_done),
    .busy   (shift_busy),
    .result (shift_res)
  );

  // One adder serves ADD, SUB and both compares; carry-out of a + ~b + 1 is a >= b.
  assign sub_mode = (in_op == OP_SUB) || (in_op == OP_SLT) || (in_op == OP_SLTU);
  assign b_eff    = sub_mode ? ~in_b : in_b;
  assign sum_ext  = {1'b0, in_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub_mode};
  assign sltu_bit = !sum_ext[XLEN];
  assign slt_bit  = (in_a[XLEN-1] != in_b[XLEN-1]) ? in_a[XLEN-1] : sum_ext[XLEN-1];

  for (genvar gi = 0; gi < XLEN; gi++) begin : g_logic
    assign xor_res[gi] = in_a[gi] ^ in_b[gi];
    assign or_res[gi]  = in_a[gi] | in_b[gi];
    assign and_res[gi] = in_a[gi] & in_b[gi];
  end

  always_comb begin
    res_next = '0;
    err_next = 1'b0;
    case (in_op)
      OP_ADD, OP_SUB:         res_next = sum_ext[XLEN-1:0];
      OP_SLL, OP_SRL, OP_SRA: res_next = shift_res;
      OP_XOR:                 res_next = xor_res;
      OP_OR:                  res_next = or_res;
      OP_AND:                 res_next = and_res;
      OP_SLT:                 res_next = {{(XLEN-1){1'b0}}, slt_bit};
      OP_SLTU:                res_next = {{(XLEN-1){1'b0}}, sltu_bit};
      default:                err_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_res_reg   <= '0;
      out_tag_reg   <= '0;
      out_err_reg   <= 1'b0;
      tag_hold_reg  <= '0;
    end else begin
      if (in_fire) tag_hold_reg <= in_tag;
      if (shift_done) begin
        out_valid_reg <= 1'b1;
        out_res_reg   <= shift_res;
        out_tag_reg   <= tag_hold_reg;
        out_err_reg   <= 1'b0;
      end else if (in_fire && !shift_start) begin
        out_valid_reg <= 1'b1;
        out_res_reg   <= res_next;
        out_tag_reg   <= in_tag;
        out_err_reg   <= err_next;
      end else if (out_fire) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_res   = out_res_reg;
  assign out_tag   = out_tag_reg;
  assign out_err   = out_err_reg;
  assign busy      = shift_busy;

endmodule

// File: tb/tb_alu_exu.sv
// Directed bench for alu_exu: one barrel-shifter instance and one iterative instance.
module tb_alu_exu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_tag;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err, b_busy;
  logic [31:0] b_out_res;
  logic [3:0]  b_out_tag;
  logic        i_in_valid, i_in_ready, i_out_valid, i_out_ready, i_out_err, i_busy;
  logic [31:0] i_out_res;
  logic [3:0]  i_out_tag;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_exu #(.XLEN(32), .TAG_W(4), .SHIFT_ITER(0)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_res(b_out_res),
    .out_tag(b_out_tag), .out_err(b_out_err), .busy(b_busy)
  );

  alu_exu #(.XLEN(32), .TAG_W(4), .SHIFT_ITER(1)) dut_i (
    .clk(clk), .rst(rst),
    .in_valid(i_in_valid), .in_ready(i_in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(i_out_valid), .out_ready(i_out_ready), .out_res(i_out_res),
    .out_tag(i_out_tag), .out_err(i_out_err), .busy(i_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One op on the barrel instance: ready on offer, result one cycle later, then drained.
  task automatic run_b(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag,
                       input logic [31:0] exp, input logic exp_err);
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_tag = tag;
    b_in_valid = 1'b1; b_out_ready = 1'b0;
    #1 check({name, "_rdy"}, b_in_ready, 1);
    @(negedge clk);
    b_in_valid = 1'b0;
    check({name, "_vld"}, b_out_valid, 1);
    check({name, "_res"}, b_out_res, exp);
    check({name, "_tag"}, b_out_tag, tag);
    check({name, "_err"}, b_out_err, exp_err);
    $display("txn %s op=%0d a=%h b=%h -> res=%h tag=%0h err=%0b",
             name, op, a, b, b_out_res, b_out_tag, b_out_err);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    check({name, "_drain"}, b_out_valid, 0);
  endtask

  // One op on the iterative instance, measuring latency, busy cycles and in_ready.
  task automatic run_i(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag,
                       input logic [31:0] exp, input logic exp_err, input int exp_lat);
    int lat, busy_n, rdy_n;
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_tag = tag;
    i_in_valid = 1'b1; i_out_ready = 1'b0;
    #1 check({name, "_rdy"}, i_in_ready, 1);
    @(negedge clk);
    i_in_valid = 1'b0;
    lat = 1; busy_n = 0; rdy_n = 0;
    while (!i_out_valid && lat < 40) begin
      if (i_busy) busy_n++;
      if (i_in_ready) rdy_n++;
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_busy_n"}, busy_n, exp_lat - 1);
    check({name, "_rdy_low"}, rdy_n, 0);
    check({name, "_res"}, i_out_res, exp);
    check({name, "_tag"}, i_out_tag, tag);
    check({name, "_err"}, i_out_err, exp_err);
    check({name, "_idle"}, i_busy, 0);
    $display("txn %s op=%0d a=%h b=%h -> res=%h tag=%0h lat=%0d busy=%0d",
             name, op, a, b, i_out_res, i_out_tag, lat, busy_n);
    i_out_ready = 1'b1;
    @(negedge clk);
    i_out_ready = 1'b0;
    check({name, "_drain"}, i_out_valid, 0);
  endtask

  // Eight ADDs through the barrel instance; toggle=1 stalls the output every other cycle.
  task automatic stream(input string name, input bit toggle);
    logic [31:0] exp_q[$];
    logic [3:0]  tag_q[$];
    logic [31:0] av, bv, held_res;
    logic [3:0]  held_tag;
    logic        held;
    int sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0; held = 1'b0;
    held_res = '0; held_tag = '0;
    while (recv < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        check({name, "_hold_vld"}, b_out_valid, 1);
        check({name, "_hold_res"}, b_out_res, held_res);
        check({name, "_hold_tag"}, b_out_tag, held_tag);
      end
      held = 1'b0;
      b_out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (b_out_valid) begin
        if (b_out_ready) begin
          if (exp_q.size() == 0) begin
            check({name, "_extra"}, b_out_valid, 0);
          end else begin
            check({name, "_res"}, b_out_res, exp_q.pop_front());
            check({name, "_tag"}, b_out_tag, tag_q.pop_front());
            $display("txn %s #%0d res=%h tag=%0h", name, recv, b_out_res, b_out_tag);
          end
          recv++;
        end else begin
          held = 1'b1; held_res = b_out_res; held_tag = b_out_tag;
        end
      end
      if (sent < 8) begin
        av = 32'h0101_0101 * (sent + 1);
        bv = 32'hF000_0000 + sent;
        in_op = OP_ADD; in_a = av; in_b = bv; in_tag = 4'(sent + 3);
        b_in_valid = 1'b1;
        #1;
        if (b_in_ready) begin
          exp_q.push_back(av + bv);
          tag_q.push_back(4'(sent + 3));
          sent++;
        end
      end else begin
        b_in_valid = 1'b0;
      end
    end
    b_in_valid = 1'b0;
    check({name, "_count"}, recv, 8);
    if (!toggle) check({name, "_cycles"}, cyc, 9);
    @(negedge clk);
    b_out_ready = 1'b0;
    check({name, "_empty"}, b_out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  seen;
    rst = 1'b1;
    in_op = OP_ADD; in_a = 32'h1; in_b = 32'h1; in_tag = 4'h1;
    b_in_valid = 1'b1; i_in_valid = 1'b1;
    b_out_ready = 1'b1; i_out_ready = 1'b1;

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_b_rdy", b_in_ready, 0);
      check("rst_b_vld", b_out_valid, 0);
      check("rst_i_rdy", i_in_ready, 0);
      check("rst_i_vld", i_out_valid, 0);
    end
    rst = 1'b0; b_in_valid = 1'b0; i_in_valid = 1'b0;
    b_out_ready = 1'b0; i_out_ready = 1'b0;
    #1;
    check("post_rst_b_rdy", b_in_ready, 1);
    check("post_rst_i_rdy", i_in_ready, 1);
    check("post_rst_res", b_out_res, 0);
    check("post_rst_tag", b_out_tag, 0);
    check("post_rst_err", b_out_err, 0);
    check("post_rst_busy", i_busy, 0);

    run_b("add_wrap", OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 4'h5, 32'h0000_0000, 1'b0);
    run_b("add",      OP_ADD,  32'h1234_5678, 32'h1111_1111, 4'h2, 32'h2345_6789, 1'b0);
    run_b("sub_wrap", OP_SUB,  32'h0000_0000, 32'h0000_0001, 4'h6, 32'hFFFF_FFFF, 1'b0);
    run_b("slt_neg",  OP_SLT,  32'h8000_0000, 32'h0000_0001, 4'h7, 32'h0000_0001, 1'b0);
    run_b("sltu_big", OP_SLTU, 32'h8000_0000, 32'h0000_0001, 4'h8, 32'h0000_0000, 1'b0);
    run_b("slt_pos",  OP_SLT,  32'h0000_0001, 32'h8000_0000, 4'h9, 32'h0000_0000, 1'b0);
    run_b("sltu_sm",  OP_SLTU, 32'h0000_0001, 32'h8000_0000, 4'hA, 32'h0000_0001, 1'b0);
    run_b("sra",      OP_SRA,  32'h8000_0000, 32'h0000_0024, 4'hB, 32'hF800_0000, 1'b0);
    run_b("srl",      OP_SRL,  32'h8000_0000, 32'h0000_0024, 4'hC, 32'h0800_0000, 1'b0);
    run_b("sll",      OP_SLL,  32'h0000_0001, 32'h0000_001F, 4'hD, 32'h8000_0000, 1'b0);
    run_b("xor",      OP_XOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h1, 32'hFF00_0FF0, 1'b0);
    run_b("or",       OP_OR,   32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h2, 32'hFFF0_0FFF, 1'b0);
    run_b("and",      OP_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 4'h3, 32'h00F0_000F, 1'b0);
    run_b("illegal",  4'd12,   32'hDEAD_BEEF, 32'h0000_0001, 4'hE, 32'h0000_0000, 1'b1);

    stream("bp", 1'b1);
    stream("tput", 1'b0);

    run_i("it_srl4",  OP_SRL,  32'h0000_00F0, 32'h0000_0004, 4'h9, 32'h0000_000F, 1'b0, 5);
    run_i("it_sll1",  OP_SLL,  32'h0000_0001, 32'h0000_0001, 4'h4, 32'h0000_0002, 1'b0, 2);
    run_i("it_sra3",  OP_SRA,  32'h8000_0000, 32'h0000_0003, 4'h5, 32'hF000_0000, 1'b0, 4);
    run_i("it_zero",  OP_SRL,  32'h0000_00F0, 32'h0000_0020, 4'h6, 32'h0000_00F0, 1'b0, 1);
    run_i("it_add",   OP_ADD,  32'h0000_0002, 32'h0000_0003, 4'h7, 32'h0000_0005, 1'b0, 1);
    run_i("it_ill",   4'd15,   32'h0000_0002, 32'h0000_0003, 4'h8, 32'h0000_0000, 1'b1, 1);

    // Reset in the middle of an 8-step shift must discard it.
    @(negedge clk);
    in_op = OP_SRL; in_a = 32'h0000_00F0; in_b = 32'h0000_0008; in_tag = 4'hF;
    i_in_valid = 1'b1; i_out_ready = 1'b0;
    @(negedge clk);
    i_in_valid = 1'b0;
    check("midrst_busy_pre", i_busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", i_busy, 0);
    check("midrst_vld", i_out_valid, 0);
    check("midrst_rdy_in_rst", i_in_ready, 0);
    rst = 1'b0;
    #1 check("midrst_rdy_after", i_in_ready, 1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (i_out_valid) seen = 1;
    end
    check("midrst_no_result", seen, 0);
    $display("txn midrst discarded shift, out_valid_seen=%0d", seen);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
